// File: rtl/cpu_pkg.sv
// Shared CPU constants: exception codes, fetch address map and fetch-stage state encoding.
package cpu_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] PC_LO      = 32'h0000_3000;
  localparam logic [31:0] PC_HI      = 32'h0000_6ffc;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc_check.sv
// Combinational bad-address detector: misaligned word or outside the legal window.
module fetch_pc_check import cpu_pkg::*; #(
  parameter logic [31:0] LO = PC_LO,
  parameter logic [31:0] HI = PC_HI
) (
  input  logic [31:0] addr,
  output logic        bad
);

  assign bad = (addr[1:0] != 2'b00) | (addr < LO) | (addr > HI);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a req/ack imem port and offers instr/pc/exc/slot to D.
// Optional FETCH_STAT_CNT_EN adds stat_deliv/stat_wait performance counters.
module fetch_stage import cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_is_jump,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [4:0]  exc_out,
  output logic        slot_out,
  output logic        f_valid
`ifdef FETCH_STAT_CNT_EN
  ,
  output logic [31:0] stat_deliv,
  output logic [31:0] stat_wait
`endif
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, drop_addr_r, buf_r, redir_tgt_r;
  logic         slot_pend_r, redir_pend_r;
  logic         bad_s, fv_s, deliver_s, flush_s, br_now_s;
  logic [31:0]  flush_pc_s, next_pc_s, word_s;

  fetch_pc_check u_pc_check (
    .addr (pc_r),
    .bad  (bad_s)
  );

  assign fv_s       = rst & (((state_r == ST_WAIT) & (imem_ack | bad_s)) | (state_r == ST_HOLD));
  assign deliver_s  = fv_s & ~stall;
  assign flush_s    = req | eret;
  assign flush_pc_s = req ? PC_HANDLER : epc;
  assign br_now_s   = br_taken & d_is_jump & ~stall;
  assign next_pc_s  = redir_pend_r ? redir_tgt_r : (br_now_s ? br_target : pc_plus4(pc_r));
  // An illegal pc always offers a nop; HOLD replays the captured word, WAIT passes the ack word through
  assign word_s     = bad_s ? 32'd0 : ((state_r == ST_HOLD) ? buf_r : imem_rdata);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT: begin
        if (flush_s) begin
          state_nxt_s = (!bad_s && !imem_ack) ? ST_DROP : ST_WAIT;
        end else if (fv_s && stall) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (flush_s || !stall) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: state_nxt_s = ST_WAIT;
    endcase
  end

  // Outputs: imem handshake and the F->D offer, forced quiet while in reset
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'd0;
    f_valid   = 1'b0;
    instr_out = 32'd0;
    exc_out   = EXC_NONE;
    slot_out  = 1'b0;
    pc_out    = pc_r;
    if (rst) begin
      f_valid  = fv_s;
      slot_out = slot_pend_r | d_is_jump;
      case (state_r)
        ST_WAIT: begin
          imem_req  = ~bad_s;
          imem_addr = pc_r;
        end
        ST_HOLD: begin
          imem_req  = 1'b0;
          imem_addr = pc_r;
        end
        ST_DROP: begin
          imem_req  = 1'b1;
          imem_addr = drop_addr_r;
        end
        default: begin
          imem_req  = 1'b0;
          imem_addr = pc_r;
        end
      endcase
      if (fv_s) begin
        instr_out = word_s;
        exc_out   = bad_s ? EXC_ADEL : EXC_NONE;
      end else begin
        instr_out = 32'd0;
        exc_out   = EXC_NONE;
      end
    end else begin
      imem_req = 1'b0;
    end
  end

  // PC, word buffer and pending slot/redirect bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r         <= PC_RESET;
      drop_addr_r  <= 32'd0;
      buf_r        <= 32'd0;
      slot_pend_r  <= 1'b0;
      redir_pend_r <= 1'b0;
      redir_tgt_r  <= 32'd0;
    end else if (flush_s) begin
      pc_r         <= flush_pc_s;
      buf_r        <= 32'd0;
      slot_pend_r  <= 1'b0;
      redir_pend_r <= 1'b0;
      // Only a fresh WAIT request becomes the stale one; in DROP the original stays outstanding
      if (state_r == ST_WAIT) begin
        drop_addr_r <= pc_r;
      end
    end else begin
      if (deliver_s) begin
        pc_r <= next_pc_s;
      end
      if ((state_r == ST_WAIT) && fv_s && stall) begin
        buf_r <= word_s;
      end
      if (deliver_s) begin
        slot_pend_r <= 1'b0;
      end else if (d_is_jump && !stall) begin
        slot_pend_r <= 1'b1;
      end
      if (deliver_s) begin
        redir_pend_r <= 1'b0;
      end else if (br_now_s) begin
        redir_pend_r <= 1'b1;
        redir_tgt_r  <= br_target;
      end
    end
  end

`ifdef FETCH_STAT_CNT_EN
  logic [31:0] stat_deliv_r, stat_wait_r;

  // Delivered-instruction and imem-wait cycle counters, free-running with wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_deliv_r <= 32'd0;
      stat_wait_r  <= 32'd0;
    end else begin
      if (deliver_s) begin
        stat_deliv_r <= stat_deliv_r + 32'd1;
      end
      if (imem_req && !imem_ack) begin
        stat_wait_r <= stat_wait_r + 32'd1;
      end
    end
  end

  assign stat_deliv = stat_deliv_r;
  assign stat_wait  = stat_wait_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised closed-loop bench: the bench plays imem and the D stage, and a sequence-level
// program-order model feeds a scoreboard that the negedge monitor checks every offered instruction against.
module tb_fetch_stage;

  localparam int          NCYC       = 4000;
  localparam int          RST2       = 2000;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, req = 1'b0, eret = 1'b0;
  logic [31:0] epc = 32'd0;
  logic        d_is_jump = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_out, pc_out;
  logic [4:0]  exc_out;
  logic        slot_out, f_valid;
`ifdef FETCH_STAT_CNT_EN
  logic [31:0] stat_deliv, stat_wait;
`endif

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req        (req),
    .eret       (eret),
    .epc        (epc),
    .d_is_jump  (d_is_jump),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .exc_out    (exc_out),
    .slot_out   (slot_out),
    .f_valid    (f_valid)
`ifdef FETCH_STAT_CNT_EN
    ,
    .stat_deliv (stat_deliv),
    .stat_wait  (stat_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        slot;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_cur, e;
  logic [31:0] m_slot_next = 32'd0;
  int          checks = 0, errors = 0;
  int          n_deliv = 0, n_wait = 0, n_total = 0;
  bit          mon_deliv = 1'b0, fv_required = 1'b0;
  bit          d_jump = 1'b0, d_taken = 1'b0, busy = 1'b0;
  logic [31:0] d_tgt = 32'd0, baddr = 32'd0;
  int          cnt = 0;

  function automatic logic is_bad(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a < 32'h0000_3000) || (a > 32'h0000_6ffc);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_pc();
    int unsigned r;
    logic [31:0] p;
    r = $urandom_range(0, 99);
    p = 32'h0000_3000 + 32'd4 * $urandom_range(0, 4095);
    if (r < 12) p = p + $urandom_range(1, 3);
    else if (r < 20) p = 32'h0000_7000 + 32'd4 * $urandom_range(0, 15);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic slot);
    m_cur.pc   = pc;
    m_cur.slot = slot;
    exp_q.push_back(m_cur);
  endtask

  // Program-order rule: after a jump comes its delay slot, after the slot the target (or fall-through)
  task automatic model_deliver(input bit jump, input bit taken, input logic [31:0] tgt);
    if (m_cur.slot) begin
      push_exp(m_slot_next, 1'b0);
    end else if (jump) begin
      m_slot_next = taken ? tgt : m_cur.pc + 32'd8;
      push_exp(m_cur.pc + 32'd4, 1'b1);
    end else begin
      push_exp(m_cur.pc + 32'd4, 1'b0);
    end
  endtask

  // Monitor: every offered instruction must be the scoreboard head; a delivery pops it
  always @(negedge clk) begin
    mon_deliv = 1'b0;
    if (!rst) begin
      chk("rst_pc_out", pc_out, RESET_PC);
      chk("rst_f_valid", 32'(f_valid), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_instr_out", instr_out, 32'd0);
    end else begin
      if (fv_required) chk("f_valid_every_cycle", 32'(f_valid), 32'd1);
      if (f_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_offer: pc_out %h offered, scoreboard empty", pc_out);
        end else begin
          e = exp_q[0];
          chk("pc_out", pc_out, e.pc);
          chk("instr_out", instr_out, is_bad(e.pc) ? 32'd0 : mem_word(e.pc));
          chk("exc_out", 32'(exc_out), is_bad(e.pc) ? 32'd4 : 32'd0);
          chk("slot_out", 32'(slot_out), 32'(e.slot));
          if (is_bad(e.pc)) chk("imem_req_on_bad_pc", 32'(imem_req), 32'd0);
          if (!stall) begin
            void'(exp_q.pop_front());
            mon_deliv = 1'b1;
            n_deliv++;
            n_total++;
          end
        end
      end else begin
        chk("bubble_instr_out", instr_out, 32'd0);
      end
    end
  end

  // Stimulus: reset, D-stage behaviour, exceptions/eret and the imem responder
  initial begin
    int idle, stall_pct, jump_pct, maxd;
    bit was_rst, flush_prev, stall_prev, flush_ok;
    logic [31:0] flush_pc;
    idle = 0; was_rst = 1'b1; flush_prev = 1'b0; stall_prev = 1'b1; flush_pc = 32'd0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 100) begin
        stall_pct = 0; jump_pct = 0; maxd = 0; flush_ok = 1'b0;
      end else if (cyc < 400) begin
        stall_pct = 0; jump_pct = 30; maxd = 3; flush_ok = 1'b0;
      end else begin
        stall_pct = 35; jump_pct = 30; maxd = 3; flush_ok = 1'b1;
      end
      if (cyc < 2 || (cyc >= RST2 && cyc < RST2 + 2)) begin
        rst = 1'b0; stall = 1'b0; req = 1'b0; eret = 1'b0;
        d_jump = 1'b0; d_is_jump = 1'b0; br_taken = 1'b0;
        imem_ack = 1'b0; busy = 1'b0; fv_required = 1'b0;
        was_rst = 1'b1; flush_prev = 1'b0; idle = 0; n_deliv = 0; n_wait = 0;
      end else begin
        rst = 1'b1;
        if (was_rst) begin
          exp_q.delete();
          push_exp(RESET_PC, 1'b0);
          d_jump = 1'b0;
          was_rst = 1'b0;
        end else if (flush_prev) begin
          exp_q.delete();
          push_exp(flush_pc, 1'b0);
          d_jump = 1'b0;
        end else if (!stall_prev) begin
          if (mon_deliv) begin
            d_jump  = !m_cur.slot && !is_bad(m_cur.pc) && ($urandom_range(0, 99) < jump_pct);
            d_taken = ($urandom_range(0, 99) < 60);
            d_tgt   = rand_pc();
            model_deliver(d_jump, d_taken, d_tgt);
          end else begin
            d_jump = 1'b0;
          end
        end
        if (mon_deliv) idle = 0;
        else idle++;
        if (idle > 300) begin
          checks++;
          errors++;
          $display("FAIL progress_watchdog: no delivery for %0d cycles, expected at most 300", idle);
          idle = 0;
        end
        stall = ($urandom_range(0, 99) < stall_pct);
        req = 1'b0; eret = 1'b0; flush_prev = 1'b0;
        epc = rand_pc();
        if (stall && flush_ok && $urandom_range(0, 99) < 10) begin
          flush_prev = 1'b1;
          if ($urandom_range(0, 1) == 0) begin
            req = 1'b1;
            eret = ($urandom_range(0, 1) == 1);
            flush_pc = HANDLER_PC;
          end else begin
            eret = 1'b1;
            flush_pc = epc;
          end
        end
        d_is_jump = d_jump;
        br_taken  = d_jump ? d_taken : ($urandom_range(0, 1) == 1);
        br_target = d_jump ? d_tgt : rand_pc();
        stall_prev = stall;
        fv_required = (cyc < 100);
        #1;
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
          if (!busy) begin
            busy = 1'b1;
            baddr = imem_addr;
            cnt = $urandom_range(0, maxd);
          end else begin
            chk("imem_addr_stable", imem_addr, baddr);
          end
          if (cnt == 0) begin
            imem_ack = 1'b1;
            imem_rdata = mem_word(baddr);
            busy = 1'b0;
          end else begin
            cnt--;
          end
        end else if (busy) begin
          chk("imem_req_held_until_ack", 32'(imem_req), 32'd1);
          busy = 1'b0;
        end
        if (imem_req && !imem_ack) n_wait++;
      end
    end
    @(posedge clk);
    #1;
    chk("enough_deliveries", 32'(n_total >= 500), 32'd1);
`ifdef FETCH_STAT_CNT_EN
    chk("stat_deliv", stat_deliv, n_deliv);
    chk("stat_wait", stat_wait, n_wait);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
